// File: rtl/neuron_accumulator_if.sv
// Product-in / result-out handshake bundle between a neuron's multiplier and its accumulator.
// Signal names follow the multiplier path's established naming.
interface neuron_accumulator_if #(
    parameter int BIT = 8
) ();
    logic               iValid;
    logic [2*BIT-2:0]   iProduct;
    logic               iLast;
    logic               oReady;
    logic               oValid;
    logic [BIT-1:0]     oNum;
    logic               iReady;

    modport slave  (input  iValid, iProduct, iLast, iReady,
                    output oReady, oValid, oNum);
    modport master (output iValid, iProduct, iLast, iReady,
                    input  oReady, oValid, oNum);
endinterface

// File: rtl/neuron_accumulator.sv
// Sums sign-magnitude products into a saturating two's-complement accumulator and
// requantizes the total to the 8-bit sign-magnitude activation format on the last term.
module neuron_accumulator #(
    parameter int BIT   = 8,
    parameter int ACC_W = 26,
    parameter bit RELU  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    neuron_accumulator_if.slave  bus
);
    localparam int PW = 2*BIT - 1;
    localparam int MW = 2*BIT - 2;

    localparam logic signed [ACC_W-1:0] PLUS_ONE = {{(ACC_W-MW-1){1'b0}}, 1'b1, {MW{1'b0}}};
    localparam logic signed [ACC_W:0]   SAT_MAX  = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0]   SAT_MIN  = -SAT_MAX;
    localparam logic [ACC_W-1:0]        ONE_LSB  = {{(ACC_W-1){1'b0}}, 1'b1};
    localparam logic [ACC_W-1:0]        HALF_Q   = {{(ACC_W-BIT+1){1'b0}}, 1'b1, {(BIT-2){1'b0}}};
    localparam logic [ACC_W-1:0]        Q_LIMIT  = {{(ACC_W-BIT){1'b0}}, 1'b1, {(BIT-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_ROUND = 2'd1,
        ST_OUT   = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [BIT-1:0]          num_q, num_d;
    logic                    valid_q, valid_d;

    // Sign=1 with zero magnitude is the +1.0 code, not negative zero.
    function automatic logic signed [ACC_W-1:0] decode(input logic [PW-1:0] p);
        logic signed [ACC_W-1:0] mag;
        mag = {{(ACC_W-MW){1'b0}}, p[MW-1:0]};
        if (!p[PW-1]) begin
            decode = mag;
        end else if (mag == {ACC_W{1'b0}}) begin
            decode = PLUS_ONE;
        end else begin
            decode = -mag;
        end
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                        input logic signed [ACC_W-1:0] d);
        logic signed [ACC_W:0] sum;
        logic signed [ACC_W:0] clip;
        sum = {a[ACC_W-1], a} + {d[ACC_W-1], d};
        if (sum > SAT_MAX) begin
            clip = SAT_MAX;
        end else if (sum < SAT_MIN) begin
            clip = SAT_MIN;
        end else begin
            clip = sum;
        end
        sat_add = clip[ACC_W-1:0];
    endfunction

    // Round half away from zero on the magnitude; 0x80 is reserved for +1.0.
    function automatic logic [BIT-1:0] requant(input logic signed [ACC_W-1:0] acc);
        logic              neg;
        logic [ACC_W-1:0]  a;
        logic [ACC_W-1:0]  q;
        neg = acc[ACC_W-1];
        a   = neg ? (~acc + ONE_LSB) : acc;
        q   = (a + HALF_Q) >> (BIT-1);
        if (q == {ACC_W{1'b0}}) begin
            requant = {BIT{1'b0}};
        end else if (neg && RELU) begin
            requant = {BIT{1'b0}};
        end else if (q >= Q_LIMIT) begin
            requant = neg ? {1'b1, {(BIT-1){1'b1}}} : {1'b1, {(BIT-1){1'b0}}};
        end else begin
            requant = {neg, q[BIT-2:0]};
        end
    endfunction

    // Next-state and datapath update for the accumulate / round / present cycle.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        num_d   = num_q;
        valid_d = valid_q;
        case (state_q)
            ST_ACC: begin
                if (bus.iValid) begin
                    acc_d   = sat_add(acc_q, decode(bus.iProduct));
                    state_d = bus.iLast ? ST_ROUND : ST_ACC;
                end else begin
                    acc_d   = acc_q;
                end
            end
            ST_ROUND: begin
                num_d   = requant(acc_q);
                valid_d = 1'b1;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (bus.iReady) begin
                    state_d = ST_ACC;
                    valid_d = 1'b0;
                    acc_d   = {ACC_W{1'b0}};
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d = ST_ACC;
                acc_d   = {ACC_W{1'b0}};
                valid_d = 1'b0;
            end
        endcase
    end

    // State and result registers; reset drops any partial sum or pending result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ACC;
            acc_q   <= {ACC_W{1'b0}};
            num_q   <= {BIT{1'b0}};
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            num_q   <= num_d;
            valid_q <= valid_d;
        end
    end

    assign bus.oReady = (state_q == ST_ACC);
    assign bus.oValid = valid_q;
    assign bus.oNum   = num_q;
endmodule

// File: tb/tb_neuron_accumulator.sv
// Drives identical product streams into a plain and a ReLU accumulator and checks both
// against an integer reference of the decode / saturate / round rules.
module tb_neuron_accumulator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iv  = 1'b0;
    logic [14:0] ip  = 15'h0000;
    logic        il  = 1'b0;
    logic        ir  = 1'b0;
    int          total = 0;
    int          bad   = 0;
    int          cur[$];

    neuron_accumulator_if #(.BIT(8)) bus0 ();
    neuron_accumulator_if #(.BIT(8)) bus1 ();

    assign bus0.iValid = iv;  assign bus0.iProduct = ip;  assign bus0.iLast = il;  assign bus0.iReady = ir;
    assign bus1.iValid = iv;  assign bus1.iProduct = ip;  assign bus1.iLast = il;  assign bus1.iReady = ir;

    neuron_accumulator #(.BIT(8), .ACC_W(26), .RELU(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    neuron_accumulator #(.BIT(8), .ACC_W(26), .RELU(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
        end
    endtask

    // Reference: exact integer sum of decoded terms, clamped, then rounded magnitude.
    function automatic logic [7:0] model(input bit relu);
        longint s = 0;
        longint lim = (64'sd1 <<< 25) - 1;
        longint a, q, d;
        int p;
        bit neg;
        logic [7:0] r;
        foreach (cur[i]) begin
            p = cur[i];
            if (p[14] == 1'b0)           d = p & 16'h3FFF;
            else if ((p & 16'h3FFF) == 0) d = 16384;
            else                          d = -(p & 16'h3FFF);
            s = s + d;
            if (s > lim)  s = lim;
            if (s < -lim) s = -lim;
        end
        neg = (s < 0);
        a = neg ? -s : s;
        q = (a + 64) / 128;
        if (q == 0)               r = 8'h00;
        else if (neg && relu)     r = 8'h00;
        else if (q >= 128)        r = neg ? 8'hFF : 8'h80;
        else                      r = {neg, 7'(q)};
        return r;
    endfunction

    task automatic run_sum(input int stall, input bit reset_in_out);
        logic [7:0] e0, e1;
        int p;
        e0 = model(1'b0);
        e1 = model(1'b1);
        foreach (cur[i]) begin
            @(negedge clk);
            chk("ready_acc", {bus1.oReady, bus0.oReady}, 32'd3);
            p  = cur[i];
            iv = 1'b1;
            ip = p[14:0];
            il = (i == cur.size() - 1);
        end
        @(negedge clk);
        iv = 1'b0;
        il = 1'b0;
        chk("round_valid", {bus1.oValid, bus0.oValid}, 32'd0);
        chk("round_ready", {bus1.oReady, bus0.oReady}, 32'd0);
        @(negedge clk);
        chk("out_valid", {bus1.oValid, bus0.oValid}, 32'd3);
        chk("num", {24'd0, bus0.oNum}, {24'd0, e0});
        chk("num_relu", {24'd0, bus1.oNum}, {24'd0, e1});
        for (int k = 0; k < stall; k++) begin
            iv = 1'($urandom_range(0, 1));
            ip = 15'($urandom);
            il = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("stall_hold", {bus1.oReady, bus1.oValid, bus1.oNum, bus0.oReady, bus0.oValid, bus0.oNum},
                {14'd0, 1'b0, 1'b1, e1, 1'b0, 1'b1, e0});
        end
        iv = 1'b0;
        il = 1'b0;
        if (reset_in_out) begin
            #2 rst = 1'b1;
            #1;
            chk("rst_out", {bus1.oValid, bus1.oNum, bus0.oValid, bus0.oNum}, 32'd0);
            chk("rst_ready", {bus1.oReady, bus0.oReady}, 32'd3);
            @(negedge clk);
            rst = 1'b0;
        end else begin
            ir = 1'b1;
            @(negedge clk);
            ir = 1'b0;
            chk("release", {bus1.oReady, bus1.oValid, bus0.oReady, bus0.oValid}, 32'b1010);
        end
    endtask

    initial begin
        int n;
        int p;
        #1;
        chk("reset_state", {bus1.oReady, bus1.oValid, bus1.oNum, bus0.oReady, bus0.oValid, bus0.oNum},
            {14'd0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00});
        @(negedge clk);
        rst = 1'b0;

        cur = '{32'h4000};                       run_sum(0, 1'b0);
        cur = '{32'h2000, 32'h5000};             run_sum(1, 1'b0);
        cur = '{32'h0040};                       run_sum(0, 1'b0);
        cur = '{32'h003F};                       run_sum(0, 1'b0);
        cur = '{32'h4040};                       run_sum(0, 1'b0);
        cur = '{32'h4000, 32'h4000, 32'h4000};   run_sum(0, 1'b0);
        cur = '{32'h7000, 32'h7000, 32'h7000};   run_sum(5, 1'b0);
        cur = '{32'h0080};                       run_sum(0, 1'b0);

        // Partial sum lost to an asynchronous reset between edges.
        @(negedge clk);
        iv = 1'b1; ip = 15'h2000; il = 1'b0;
        @(negedge clk);
        iv = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_mid", {bus1.oValid, bus1.oNum, bus0.oValid, bus0.oNum}, 32'd0);
        iv = 1'b1; ip = 15'h7FFF; il = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_hold_ready", {bus1.oReady, bus0.oReady}, 32'd3);
        iv = 1'b0; il = 1'b0;
        rst = 1'b0;
        cur = '{32'h1000};                       run_sum(0, 1'b0);

        // Pending result lost to reset while waiting for the consumer.
        cur = '{32'h2000};                       run_sum(2, 1'b1);
        cur = '{32'h0100};                       run_sum(0, 1'b0);

        for (int t = 0; t < 60; t++) begin
            n = $urandom_range(1, 7);
            cur = {};
            for (int j = 0; j < n; j++) begin
                case ($urandom_range(0, 3))
                    0:       p = 32'h4000;
                    1:       p = 32'h7000 + $urandom_range(0, 32'h0FFF);
                    2:       p = $urandom_range(0, 32'h00FF) | ($urandom_range(0, 1) << 14);
                    default: p = $urandom_range(0, 32'h7FFF);
                endcase
                cur.push_back(p);
            end
            run_sum($urandom_range(0, 3), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
